// File: rtl/io_bus_arbiter_if.sv
// Bundle of both requester ports and the shared 4-bit/8-bit I/O port bus.
// The arbiter connects through the slave modport; requesters and the bus model use master.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_data_oe;
    logic [DATA_W-1:0] io_rdata;
    logic              io_oe;
    logic              io_we;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output io_addr, io_wdata, io_data_oe, io_oe, io_we,
        input  io_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  io_addr, io_wdata, io_data_oe, io_oe, io_we,
        output io_rdata
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the I/O port bus between the CPU (m0) and a debug master (m1).
// Each access runs GRANT, WAIT_STATES+1 ACCESS cycles and DONE; every output comes from a flop.
module io_bus_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_owner;
    logic              w_nextOwner;
    logic              r_lastOwner;
    logic              r_we;
    logic [2:0]        r_waitCnt;
    logic [ADDR_W-1:0] r_ioAddr;
    logic [DATA_W-1:0] r_ioWdata;
    logic [DATA_W-1:0] r_m0Rdata;
    logic [DATA_W-1:0] r_m1Rdata;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_ioWe;
    logic              r_ioOe;

    logic              w_start;
    logic              w_lastAccess;
    logic              w_selWe;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // On a tie the requester that did not own the last transaction wins.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        case (r_state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    w_nextState = GRANT;
                    if (bus.m0_req && bus.m1_req) begin
                        w_nextOwner = ~r_lastOwner;
                    end else begin
                        w_nextOwner = bus.m1_req;
                    end
                end
            end
            GRANT:   w_nextState = ACCESS;
            ACCESS: begin
                if (r_waitCnt == 3'd0) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_start      = (r_state == IDLE) && (w_nextState == GRANT);
    assign w_lastAccess = (r_state == ACCESS) && (r_waitCnt == 3'd0);
    assign w_selWe      = w_nextOwner ? bus.m1_we    : bus.m0_we;
    assign w_selAddr    = w_nextOwner ? bus.m1_addr  : bus.m0_addr;
    assign w_selWdata   = w_nextOwner ? bus.m1_wdata : bus.m0_wdata;

    // Requester inputs are captured once at the start, so later changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_ioAddr  <= '0;
            r_ioWdata <= '0;
        end else if (w_start) begin
            r_owner   <= w_nextOwner;
            r_we      <= w_selWe;
            r_ioAddr  <= w_selAddr;
            r_ioWdata <= w_selWdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastOwner <= 1'b1;
        end else if (r_state == DONE) begin
            r_lastOwner <= r_owner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt <= 3'd0;
        end else if (r_state == GRANT) begin
            r_waitCnt <= 3'(WAIT_STATES);
        end else if ((r_state == ACCESS) && (r_waitCnt != 3'd0)) begin
            r_waitCnt <= r_waitCnt - 3'd1;
        end
    end

    // Outputs are computed from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_ioWe  <= 1'b0;
            r_ioOe  <= 1'b0;
        end else begin
            r_gnt0  <= (w_nextState != IDLE) && !w_nextOwner;
            r_gnt1  <= (w_nextState != IDLE) &&  w_nextOwner;
            r_done0 <= (w_nextState == DONE) && !r_owner;
            r_done1 <= (w_nextState == DONE) &&  r_owner;
            r_ioWe  <= (w_nextState == ACCESS) &&  r_we;
            r_ioOe  <= (w_nextState == ACCESS) && !r_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0Rdata <= '0;
            r_m1Rdata <= '0;
        end else if (w_lastAccess && !r_we) begin
            if (r_owner) begin
                r_m1Rdata <= bus.io_rdata;
            end else begin
                r_m0Rdata <= bus.io_rdata;
            end
        end
    end

    assign bus.m0_gnt     = r_gnt0;
    assign bus.m1_gnt     = r_gnt1;
    assign bus.m0_done    = r_done0;
    assign bus.m1_done    = r_done1;
    assign bus.m0_rdata   = r_m0Rdata;
    assign bus.m1_rdata   = r_m1Rdata;
    assign bus.io_addr    = r_ioAddr;
    assign bus.io_wdata   = r_ioWdata;
    assign bus.io_we      = r_ioWe;
    assign bus.io_oe      = r_ioOe;
    assign bus.io_data_oe = r_ioWe;

    gntExclusive: assert property (@(posedge clk) disable iff (!reset) !(r_gnt0 && r_gnt1));
    strobeExclusive: assert property (@(posedge clk) disable iff (!reset) !(r_ioWe && r_ioOe));

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: a transaction-level reference model checked every cycle,
// plus hand-computed expectations for reset, write, read, contention, withdrawal and mid-access reset.
module tb_io_bus_arbiter;

    localparam int WS = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    io_bus_arbiter #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current transaction (-1 when the bus is free).
    int         mIdx      = -1;
    bit         mOwner    = 1'b0;
    bit         mLast     = 1'b1;
    bit         mWe       = 1'b0;
    logic [3:0] mAddr     = 4'h0;
    logic [7:0] mWdata    = 8'h00;
    logic [7:0] mRdata[2] = '{8'h00, 8'h00};
    logic       mPick;

    assign mPick = (bus.m0_req && bus.m1_req) ? !mLast : bus.m1_req;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mIdx = -1; mOwner = 1'b0; mLast = 1'b1; mWe = 1'b0;
            mAddr = 4'h0; mWdata = 8'h00; mRdata[0] = 8'h00; mRdata[1] = 8'h00;
        end else if (mIdx < 0) begin
            if (bus.m0_req || bus.m1_req) begin
                mOwner = mPick;
                mWe    = mPick ? bus.m1_we    : bus.m0_we;
                mAddr  = mPick ? bus.m1_addr  : bus.m0_addr;
                mWdata = mPick ? bus.m1_wdata : bus.m0_wdata;
                mIdx   = 0;
            end
        end else begin
            if (mIdx == WS + 1 && !mWe) mRdata[mOwner] = bus.io_rdata;
            if (mIdx == WS + 2) begin
                mLast = mOwner;
                mIdx  = -1;
            end else begin
                mIdx++;
            end
        end
    end

    logic eAcc;
    assign eAcc = (mIdx >= 1) && (mIdx <= WS + 1);

    initial forever begin
        @(negedge clk);
        checkOutput("mdl_m0_gnt",  bus.m0_gnt,  (mIdx >= 0) && !mOwner);
        checkOutput("mdl_m1_gnt",  bus.m1_gnt,  (mIdx >= 0) &&  mOwner);
        checkOutput("mdl_m0_done", bus.m0_done, (mIdx == WS + 2) && !mOwner);
        checkOutput("mdl_m1_done", bus.m1_done, (mIdx == WS + 2) &&  mOwner);
        checkOutput("mdl_io_we",   bus.io_we,   eAcc && mWe);
        checkOutput("mdl_io_oe",   bus.io_oe,   eAcc && !mWe);
        checkOutput("mdl_data_oe", bus.io_data_oe, eAcc && mWe);
        checkOutput("mdl_io_addr", bus.io_addr,  mAddr);
        checkOutput("mdl_io_wdata", bus.io_wdata, mWdata);
        checkOutput("mdl_m0_rdata", bus.m0_rdata, mRdata[0]);
        checkOutput("mdl_m1_rdata", bus.m1_rdata, mRdata[1]);
    end

    task automatic applyStimulus(input bit req0, input bit we0, input logic [3:0] a0, input logic [7:0] d0,
                                 input bit req1, input bit we1, input logic [3:0] a1, input logic [7:0] d1);
        bus.m0_req = req0; bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = req1; bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int weCnt, oeCnt, doneCnt, doneAt, overlap, idleRun, grants, dones;
        bit prevAny, anyG;
        int order[$];
        int expOrder[6];
        expOrder = '{0, 1, 0, 1, 0, 1};
        bus.io_rdata = 8'hEE;

        // Reset held with m0 already requesting a write of 0xA5 to port 3
        applyStimulus(1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt",   {bus.m0_gnt, bus.m1_gnt}, 0);
        checkOutput("rst_done",  {bus.m0_done, bus.m1_done}, 0);
        checkOutput("rst_strb",  {bus.io_we, bus.io_oe, bus.io_data_oe}, 0);
        checkOutput("rst_addr",  bus.io_addr, 0);
        reset = 1'b1;

        weCnt = 0; oeCnt = 0; doneCnt = 0; doneAt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("rel_m0_gnt", bus.m0_gnt, 1);
                checkOutput("wr_grant_addr", bus.io_addr, 4'h3);
                checkOutput("wr_grant_strb", {bus.io_we, bus.io_oe}, 0);
            end
            if (bus.io_we) begin
                weCnt++;
                checkOutput("wr_wdata", bus.io_wdata, 8'hA5);
                checkOutput("wr_data_oe", bus.io_data_oe, 1);
            end
            if (bus.io_oe) oeCnt++;
            if (bus.m0_done) begin doneCnt++; doneAt = c; end
            if (c == 4) bus.m0_req = 1'b0;
            if (c == 6) checkOutput("wr_no_regrant", bus.m0_gnt, 0);
        end
        checkOutput("wr_we_cycles", weCnt, 2);
        checkOutput("wr_oe_cycles", oeCnt, 0);
        checkOutput("wr_done_cycle", doneAt, 4);
        checkOutput("wr_done_count", doneCnt, 1);

        // m1 reads port F; the bus returns 0x5C only during the final ACCESS cycle
        applyStimulus(1'b0, 1'b0, 4'h3, 8'hA5, 1'b1, 1'b0, 4'hF, 8'h00);
        oeCnt = 0; weCnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("rd_m1_gnt", bus.m1_gnt, 1);
                checkOutput("rd_addr", bus.io_addr, 4'hF);
            end
            if (bus.io_oe) oeCnt++;
            if (bus.io_we) weCnt++;
            if (c == 3) bus.io_rdata = 8'h5C;
            if (c == 4) begin
                checkOutput("rd_m1_done", bus.m1_done, 1);
                checkOutput("rd_m1_rdata", bus.m1_rdata, 8'h5C);
                checkOutput("rd_m0_rdata", bus.m0_rdata, 8'h00);
                bus.io_rdata = 8'hEE;
                bus.m1_req   = 1'b0;
            end
        end
        checkOutput("rd_oe_cycles", oeCnt, 2);
        checkOutput("rd_we_cycles", weCnt, 0);

        // Both masters hold requests: six grants must alternate starting with m0
        applyStimulus(1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b0, 4'h2, 8'h22);
        overlap = 0; idleRun = 0; grants = 0; dones = 0; prevAny = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            anyG = bus.m0_gnt || bus.m1_gnt;
            if (bus.m0_gnt && bus.m1_gnt) overlap++;
            if (anyG && !prevAny) begin
                order.push_back(bus.m1_gnt ? 1 : 0);
                if (grants > 0) checkOutput("ct_idle_gap", idleRun, 1);
                grants++;
                idleRun = 0;
            end
            if (!anyG) idleRun++;
            prevAny = anyG;
            if (bus.m0_done || bus.m1_done) dones++;
            if (dones == 6) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
                break;
            end
        end
        checkOutput("ct_done_count", dones, 6);
        checkOutput("ct_grant_count", order.size(), 6);
        checkOutput("ct_overlap", overlap, 0);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            checkOutput($sformatf("ct_order%0d", i), order[i], expOrder[i]);
        end
        @(negedge clk);

        // m0 withdraws its request and changes address/data mid-transaction
        applyStimulus(1'b1, 1'b1, 4'h5, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    checkOutput("wd_m0_gnt", bus.m0_gnt, 1);
                    checkOutput("wd_addr_grant", bus.io_addr, 4'h5);
                end
                2: begin
                    bus.m0_req = 1'b0; bus.m0_addr = 4'h9; bus.m0_wdata = 8'hFF; bus.m0_we = 1'b0;
                end
                3: begin
                    checkOutput("wd_addr_held", bus.io_addr, 4'h5);
                    checkOutput("wd_wdata_held", bus.io_wdata, 8'h3C);
                    checkOutput("wd_we_held", bus.io_we, 1);
                end
                4: checkOutput("wd_m0_done", bus.m0_done, 1);
                default: begin
                    checkOutput("wd_no_regrant", bus.m0_gnt, 0);
                    checkOutput("wd_addr_idle", bus.io_addr, 4'h5);
                end
            endcase
        end

        // Reset during an m0 write: strobe drops at once, no done, then m1 wins with m0 idle
        applyStimulus(1'b1, 1'b1, 4'h7, 8'h42, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("mr_we_before", bus.io_we, 1);
        #2;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h7, 8'h42, 1'b1, 1'b1, 4'h4, 8'h99);
        #1;
        checkOutput("mr_we_async", bus.io_we, 0);
        checkOutput("mr_data_oe_async", bus.io_data_oe, 0);
        checkOutput("mr_gnt_async", bus.m0_gnt, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("mr_no_done", bus.m0_done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mr_m1_first", {bus.m1_gnt, bus.m0_gnt}, 2'b10);

        // Second mid-transaction reset with both requesting: m0 wins the first tie
        #2;
        reset = 1'b0;
        bus.m0_req = 1'b1; bus.m0_addr = 4'h6; bus.m0_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mr_tie_m0", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
        checkOutput("mr_tie_addr", bus.io_addr, 4'h6);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
